// File: rtl/ppm_rx_pkg.sv
// Shared types and constants for the PPM receive frame buffer.
// Imported by the CRC helper and by the top-level buffer.
package ppm_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK,
    DRAIN
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_CRC   = 2'd1,
    ERR_SHORT = 2'd2,
    ERR_OVF   = 2'd3
  } err_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;

endpackage

// File: rtl/ppm_crc16_byte.sv
// Combinational byte-wide CRC-16 update, poly 0x1021, MSB-first,
// unrolled into eight single-bit shift/XOR steps.
module ppm_crc16_byte
  import ppm_rx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  always_comb begin
    logic [15:0] c;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data_in[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                    c = {c[14:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/ppm_rx_frame_buffer.sv
// Captures one PPM-decoded frame, checks its trailing CRC-16 and drains the
// payload over a valid/ready stream; bad, short or oversize frames are dropped.
module ppm_rx_frame_buffer
  import ppm_rx_pkg::*;
#(
  parameter int          DEPTH    = 32,
  parameter int          AW       = 5,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       d_en,
  input  logic       f_en,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       frm_ok,
  output logic       frm_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW:0] LEN_MIN = (AW + 1)'(3);

  state_e      state_q, state_d;
  logic        f_q;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] plen_q, plen_d;
  logic [15:0] crc_q, crc_d, crc_upd;
  logic        ovf_q, ovf_d;
  err_e        err_code_q, err_code_d, chk_code;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  logic [7:0]  m_data_q;

  logic          rise, fall, handshake;
  logic          mem_we, rd_load;
  logic [AW-1:0] rd_addr;
  logic [7:0]    mem [DEPTH];

  assign rise      = f_en & ~f_q;
  assign fall      = ~f_en & f_q;
  assign handshake = m_valid_q & m_ready;

  ppm_crc16_byte u_crc (
    .crc_in  (crc_q),
    .data_in (din),
    .crc_out (crc_upd)
  );

  // Overflow wins over length, length over CRC; a good frame leaves a zero residue.
  always_comb begin
    chk_code = ERR_NONE;
    if (ovf_q)                  chk_code = ERR_OVF;
    else if (wr_ptr_q < LEN_MIN) chk_code = ERR_SHORT;
    else if (crc_q != 16'h0000) chk_code = ERR_CRC;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    plen_d     = plen_q;
    crc_d      = crc_q;
    ovf_d      = ovf_q;
    err_code_d = err_code_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    mem_we     = 1'b0;
    rd_load    = 1'b0;
    rd_addr    = rd_ptr_q[AW-1:0] + AW'(1);
    frm_ok     = 1'b0;
    frm_err    = 1'b0;
    err_code   = err_code_q;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d  = RECV;
          wr_ptr_d = '0;
          crc_d    = CRC_INIT;
          ovf_d    = 1'b0;
        end
      end
      RECV: begin
        if (d_en) begin
          if (wr_ptr_q < DEPTH_W) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
            crc_d    = crc_upd;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (fall) state_d = CHECK;
      end
      CHECK: begin
        err_code   = chk_code;
        err_code_d = chk_code;
        if (chk_code != ERR_NONE) begin
          frm_err = 1'b1;
          state_d = IDLE;
        end else begin
          frm_ok    = 1'b1;
          plen_d    = wr_ptr_q - (AW + 1)'(2);
          rd_ptr_d  = '0;
          rd_load   = 1'b1;
          rd_addr   = '0;
          m_valid_d = 1'b1;
          m_last_d  = (wr_ptr_q == LEN_MIN);
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (handshake) begin
          if (m_last_q) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            state_d   = IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
            rd_load  = 1'b1;
            m_last_d = (rd_ptr_q + (AW + 1)'(2) == plen_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      f_q        <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      plen_q     <= '0;
      crc_q      <= CRC_INIT;
      ovf_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      f_q        <= f_en;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      plen_q     <= plen_d;
      crc_q      <= crc_d;
      ovf_q      <= ovf_d;
      err_code_q <= err_code_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q[AW-1:0]] <= din;
  end

  // Synchronous read port doubles as the m_data register; it only moves on a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       m_data_q <= '0;
    else if (rd_load) m_data_q <= mem[rd_addr];
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q == CHECK) || (state_q == DRAIN);

endmodule

// File: tb/tb_ppm_rx_frame_buffer.sv
// Self-checking bench for ppm_rx_frame_buffer: directed scenarios plus random
// frames, compared against a queue-based frame model.
module tb_ppm_rx_frame_buffer;

  localparam int DEPTH = 32;
  localparam int TMO   = 400;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       d_en = 1'b0;
  logic       f_en = 1'b0;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_valid, m_last, frm_ok, frm_err, busy;
  logic [1:0] err_code;

  ppm_rx_frame_buffer #(.DEPTH(DEPTH), .AW(5), .CRC_INIT(16'hFFFF)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .d_en     (d_en),
    .f_en     (f_en),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .frm_ok   (frm_ok),
    .frm_err  (frm_err),
    .err_code (err_code),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Sink ready policy: 0 always, 1 toggle, 2 random, 3 stalled
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Observation queues, filled on the falling edge
  logic [7:0] data_q[$];
  bit         last_q[$];
  int         beat_cyc[$];
  int         ev_q[$];
  int         ev_cyc[$];
  logic       pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) check("stall_hold", {23'd0, m_valid, m_data}, {23'd0, 1'b1, pd});
      if (frm_ok || frm_err) begin
        ev_q.push_back(frm_ok ? (frm_err ? 8 : 4 + int'(err_code)) : int'(err_code));
        ev_cyc.push_back(cyc);
      end
      if (m_valid && m_ready) begin
        data_q.push_back(m_data);
        last_q.push_back(m_last);
        beat_cyc.push_back(cyc);
      end
      pv = m_valid;
      pr = m_ready;
      pd = m_data;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] crc_of(input bq_t b);
    logic [15:0] r;
    r = 16'hFFFF;
    foreach (b[i]) begin
      for (int k = 7; k >= 0; k--) begin
        if (r[15] ^ b[i][k]) r = {r[14:0], 1'b0} ^ 16'h1021;
        else                 r = {r[14:0], 1'b0};
      end
    end
    return r;
  endfunction

  function automatic int exp_code(input bq_t b);
    if (b.size() > DEPTH) return 3;
    if (b.size() < 3)     return 2;
    if (crc_of(b) != 16'h0000) return 1;
    return 0;
  endfunction

  function automatic bq_t with_crc(input bq_t p);
    bq_t         r;
    logic [15:0] c;
    r = p;
    c = crc_of(p);
    r.push_back(c[15:8]);
    r.push_back(c[7:0]);
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic send_frame(input bq_t b, input bit gaps, input bit fall_with_last);
    @(posedge clk); #1;
    f_en = 1'b1;
    d_en = 1'b0;
    foreach (b[i]) begin
      @(posedge clk); #1;
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          d_en = 1'b0;
          @(posedge clk); #1;
        end
      end
      d_en = 1'b1;
      din  = b[i];
      if (fall_with_last && i == b.size() - 1) f_en = 1'b0;
    end
    @(posedge clk); #1;
    d_en = 1'b0;
    f_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic clear_obs();
    data_q.delete();
    last_q.delete();
    beat_cyc.delete();
    ev_q.delete();
    ev_cyc.delete();
  endtask

  task automatic finish_frame(input string tag, input bq_t b, input bit consec);
    int code, plen, t;
    code = exp_code(b);
    plen = (code == 0) ? b.size() - 2 : 0;
    t = 0;
    while ((ev_q.size() == 0 || data_q.size() < plen || m_valid) && t < TMO) begin
      @(posedge clk); #2;
      t++;
    end
    repeat (3) @(posedge clk);
    #2;
    check({tag, "_timeout"}, 32'(t < TMO), 32'd1);
    check({tag, "_events"}, ev_q.size(), 32'd1);
    if (ev_q.size() > 0) check({tag, "_pulse"}, ev_q[0], (code == 0) ? 4 : code);
    check({tag, "_errcode_held"}, 32'(err_code), code);
    check({tag, "_beats"}, data_q.size(), plen);
    for (int i = 0; i < plen && i < data_q.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), 32'(data_q[i]), 32'(b[i]));
      check($sformatf("%s_last%0d", tag, i), 32'(last_q[i]), 32'(i == plen - 1));
      if (consec && ev_cyc.size() > 0)
        check($sformatf("%s_cyc%0d", tag, i), beat_cyc[i], ev_cyc[0] + 1 + i);
    end
    check({tag, "_idle"}, {30'd0, busy, m_valid}, 32'd0);
    clear_obs();
  endtask

  task automatic wait_event(input string tag);
    int t;
    t = 0;
    while (ev_q.size() == 0 && t < TMO) begin
      @(posedge clk); #2;
      t++;
    end
    check({tag, "_wait"}, 32'(t < TMO), 32'd1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_outs"}, {19'd0, m_data, m_valid, m_last, frm_ok, frm_err, err_code, busy},
          32'd0);
  endtask

  // ---------------- stimulus ----------------
  bq_t f_good, f_bad, f_short, f_ovf, f_part, f_rand, pay;

  initial begin
    f_good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
    f_bad  = f_good;
    f_bad[10] = 8'hB0;
    f_short = '{8'hAA, 8'h55};
    f_ovf.delete();
    for (int i = 0; i < 33; i++) f_ovf.push_back(8'(i * 7 + 3));
    f_part = '{8'h11, 8'h22, 8'h33, 8'h44};

    #2;
    check_quiet("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ready_mode = 0;

    // 1: known-good frame, always ready
    send_frame(f_good, 1'b0, 1'b1);
    finish_frame("s1", f_good, 1'b1);

    // 2: corrupted CRC byte
    send_frame(f_bad, 1'b0, 1'b0);
    finish_frame("s2", f_bad, 1'b0);

    // 3: short and oversize frames
    send_frame(f_short, 1'b0, 1'b0);
    finish_frame("s3_short", f_short, 1'b0);
    send_frame(f_ovf, 1'b0, 1'b1);
    finish_frame("s3_ovf", f_ovf, 1'b0);

    // 4: toggling ready
    ready_mode = 1;
    send_frame(f_good, 1'b1, 1'b0);
    finish_frame("s4", f_good, 1'b0);

    // 5: second frame arrives while the first is stalled in drain
    ready_mode = 3;
    send_frame(f_good, 1'b0, 1'b1);
    wait_event("s5");
    check("s5_busy", 32'(busy), 32'd1);
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(with_crc(pay), 1'b0, 1'b1);
    ready_mode = 0;
    finish_frame("s5_first", f_good, 1'b0);
    pay = '{8'h01, 8'h02, 8'h03};
    send_frame(with_crc(pay), 1'b0, 1'b0);
    finish_frame("s5_third", with_crc(pay), 1'b1);

    // 6: reset mid-receive (with an error code held) and mid-drain
    send_frame(f_bad, 1'b0, 1'b0);
    finish_frame("s6_pre", f_bad, 1'b0);
    @(posedge clk); #1 f_en = 1'b1;
    foreach (f_part[i]) begin
      @(posedge clk); #1;
      d_en = 1'b1;
      din  = f_part[i];
    end
    @(posedge clk); #1;
    d_en  = 1'b0;
    f_en  = 1'b0;
    rst_n = 1'b0;
    #1 check_quiet("s6_rst_recv");
    @(posedge clk); #1 rst_n = 1'b1;
    clear_obs();

    ready_mode = 3;
    send_frame(f_good, 1'b0, 1'b1);
    wait_event("s6_drain");
    repeat (2) @(posedge clk);
    #1 check("s6_pre_valid", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    #1 check_quiet("s6_rst_drain");
    @(posedge clk); #1 rst_n = 1'b1;
    ready_mode = 0;
    clear_obs();
    send_frame(f_good, 1'b0, 1'b1);
    finish_frame("s6_post", f_good, 1'b1);

    // Random frames: good, corrupted, short and oversize, random gaps and ready
    ready_mode = 2;
    for (int n = 0; n < 30; n++) begin
      int kind, len;
      kind = $urandom_range(0, 3);
      f_rand.delete();
      if (kind <= 1) begin
        len = $urandom_range(1, 32);
        for (int i = 0; i < len; i++) f_rand.push_back(8'($urandom));
        f_rand = with_crc(f_rand);
        if (kind == 1) begin
          int p;
          p = $urandom_range(0, f_rand.size() - 1);
          f_rand[p] = f_rand[p] ^ 8'(1 << $urandom_range(0, 7));
        end
      end else begin
        len = (kind == 2) ? $urandom_range(0, 2) : $urandom_range(33, 36);
        for (int i = 0; i < len; i++) f_rand.push_back(8'($urandom));
      end
      send_frame(f_rand, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      finish_frame($sformatf("rnd%0d", n), f_rand, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
